// File: rtl/reg_file_onehot_pkg.sv
// Shared sizing constants, types and write-enable classification helpers for the
// register file.
package reg_file_onehot_pkg;

  localparam int REG_NUM  = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  typedef logic [REG_NUM-1:0] we_vec_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [REG_AW-1:0]  raddr_t;

  // Zero or one bit set: clearing the lowest set bit must leave nothing behind.
  function automatic logic at_most_one(input we_vec_t v);
    return (v & (v - 1'b1)) == '0;
  endfunction

  function automatic logic is_onehot(input we_vec_t v);
    return (v != '0) && at_most_one(v);
  endfunction

endpackage

// File: rtl/reg_file_onehot_if.sv
// Write/read bus of the register file. The decoder/operand stage side uses the
// master modport, and the register file uses the slave modport.
interface reg_file_onehot_if
  import reg_file_onehot_pkg::*;
#(
  parameter int CNT_W = 16
);
  we_vec_t          iWe;
  data_t            iWdata;
  raddr_t           iRaddr1;
  raddr_t           iRaddr2;
  data_t            oRdata1;
  data_t            oRdata2;
  logic             oErr;
  logic [CNT_W-1:0] oWrCount;

  modport master (
    output iWe, iWdata, iRaddr1, iRaddr2,
    input  oRdata1, oRdata2, oErr, oWrCount
  );

  modport slave (
    input  iWe, iWdata, iRaddr1, iRaddr2,
    output oRdata1, oRdata2, oErr, oWrCount
  );
endinterface

// File: rtl/reg_file_onehot_reg_cell.sv
// A single DATA_W-bit storage register. Synchronous reset takes priority over the
// write enable.
module reg_cell
  import reg_file_onehot_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_we,
  input  data_t i_d,
  output data_t o_q
);

  data_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file_onehot.sv
// 32x32 register file fed by a one-hot write decoder. It has two combinational
// read ports, $zero hardwired, optional write bypass, and a sticky multi-hot error flag.
module reg_file_onehot
  import reg_file_onehot_pkg::*;
#(
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
)(
  input logic               clk,
  input logic               rst,
  reg_file_onehot_if.slave  bus
);

  logic                      w_one_hot;
  logic                      w_multi_hot;
  logic                      w_accept;
  logic [REG_NUM-1:1]        w_cell_we;
  logic [REG_NUM-1:0][DATA_W-1:0] w_regs;
  data_t                     w_rdata1;
  data_t                     w_rdata2;
  logic                      r_err;
  logic [CNT_W-1:0]          r_wr_count;

  assign w_one_hot   = is_onehot(bus.iWe);
  assign w_multi_hot = !at_most_one(bus.iWe);
  // A lone bit 0 is one-hot but targets $zero, so it is not counted.
  assign w_accept    = w_one_hot && !bus.iWe[ZERO_REG];
  assign w_cell_we   = w_one_hot ? bus.iWe[REG_NUM-1:1] : '0;

  assign w_regs[ZERO_REG] = '0;

  for (genvar g = 1; g < REG_NUM; g++) begin : g_cell
    reg_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_cell_we[g]),
      .i_d  (bus.iWdata),
      .o_q  (w_regs[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_multi_hot) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Bypass only applies when this cycle's write will actually land in the addressed register.
  always_comb begin
    w_rdata1 = w_regs[bus.iRaddr1];
    w_rdata2 = w_regs[bus.iRaddr2];
    if (BYPASS && !rst && w_one_hot) begin
      if (bus.iRaddr1 != raddr_t'(ZERO_REG) && bus.iWe[bus.iRaddr1]) begin
        w_rdata1 = bus.iWdata;
      end
      if (bus.iRaddr2 != raddr_t'(ZERO_REG) && bus.iWe[bus.iRaddr2]) begin
        w_rdata2 = bus.iWdata;
      end
    end
  end

  assign bus.oRdata1  = w_rdata1;
  assign bus.oRdata2  = w_rdata2;
  assign bus.oErr     = r_err;
  assign bus.oWrCount = r_wr_count;

endmodule

// File: tb/tb_reg_file_onehot.sv
// Randomized and directed bench. It drives two register files from the same stimulus,
// one with no bypass and a 16-bit counter and one with bypass and a 4-bit counter.
module tb_reg_file_onehot;
  import reg_file_onehot_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tb_rst;
  logic [31:0] tb_we;
  logic [31:0] tb_wd;
  logic [4:0]  tb_a1;
  logic [4:0]  tb_a2;
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_onehot_if #(.CNT_W(16)) bus0 ();
  reg_file_onehot_if #(.CNT_W(4))  bus1 ();

  assign bus0.iWe = tb_we;  assign bus0.iWdata = tb_wd;
  assign bus0.iRaddr1 = tb_a1;  assign bus0.iRaddr2 = tb_a2;
  assign bus1.iWe = tb_we;  assign bus1.iWdata = tb_wd;
  assign bus1.iRaddr1 = tb_a1;  assign bus1.iRaddr2 = tb_a2;

  reg_file_onehot #(.BYPASS(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst(tb_rst), .bus(bus0));
  reg_file_onehot #(.BYPASS(1'b1), .CNT_W(4))  dut1 (.clk(clk), .rst(tb_rst), .bus(bus1));

  // Behavioural model: plain array of register contents, error flag and an unbounded write count.
  logic [31:0] m_mem [32];
  bit          m_err;
  int unsigned m_cnt;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_err = 0;
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (tb_rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_err = 0;
      m_cnt = 0;
    end else if ($countones(tb_we) >= 2) begin
      m_err = 1;
    end else if ($countones(tb_we) == 1) begin
      for (int i = 1; i < 32; i++) begin
        if (tb_we[i]) begin
          m_mem[i] = tb_wd;
          m_cnt    = m_cnt + 1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && !tb_rst && $countones(tb_we) == 1 && tb_we[a]) return tb_wd;
    return m_mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd1_nobyp", bus0.oRdata1, exp_read(tb_a1, 1'b0));
      chk("rd2_nobyp", bus0.oRdata2, exp_read(tb_a2, 1'b0));
      chk("err_nobyp", {31'h0, bus0.oErr}, {31'h0, m_err});
      chk("cnt16",     {16'h0, bus0.oWrCount}, {16'h0, m_cnt[15:0]});
      chk("rd1_byp",   bus1.oRdata1, exp_read(tb_a1, 1'b1));
      chk("rd2_byp",   bus1.oRdata2, exp_read(tb_a2, 1'b1));
      chk("err_byp",   {31'h0, bus1.oErr}, {31'h0, m_err});
      chk("cnt4",      {28'h0, bus1.oWrCount}, {28'h0, m_cnt[3:0]});
    end
  end

  task automatic drive(input logic [31:0] we, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic r);
    @(posedge clk);
    #1;
    tb_we = we; tb_wd = wd; tb_a1 = a1; tb_a2 = a2; tb_rst = r;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int unsigned sel;
    tb_rst = 1'b1; tb_we = '0; tb_wd = '0; tb_a1 = '0; tb_a2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // The register file reads zero everywhere after reset.
    for (int a = 0; a < 32; a++) begin
      drive(32'h0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
      mid();
      chk("lit_reset_rd1", bus0.oRdata1, 32'h0);
      chk("lit_reset_rd2", bus1.oRdata2, 32'h0);
    end
    chk("lit_reset_err", {31'h0, bus0.oErr}, 32'h0);
    chk("lit_reset_cnt", {16'h0, bus0.oWrCount}, 32'h0);

    // A write to r3 bypasses in the same cycle and is stored for the next cycle.
    drive(32'h0000_0008, 32'hDEAD_BEEF, 5'd3, 5'd3, 1'b0);
    mid();
    chk("lit_byp_same", bus1.oRdata1, 32'hDEAD_BEEF);
    chk("lit_nobyp_same", bus0.oRdata1, 32'h0);
    drive(32'h0, 32'h0, 5'd3, 5'd3, 1'b0);
    mid();
    chk("lit_r3_next", bus0.oRdata1, 32'hDEAD_BEEF);
    chk("lit_cnt1", {16'h0, bus0.oWrCount}, 32'h1);

    // A write with only bit 0 set is discarded.
    drive(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
    mid();
    chk("lit_r0_byp", bus1.oRdata1, 32'h0);
    drive(32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    mid();
    chk("lit_r0", bus0.oRdata1, 32'h0);
    chk("lit_r0_cnt", {16'h0, bus0.oWrCount}, 32'h1);
    chk("lit_r0_err", {31'h0, bus0.oErr}, 32'h0);

    // A multi-hot write changes no register and sets the sticky error flag.
    drive(32'h0000_0002, 32'h1111_1111, 5'd1, 5'd2, 1'b0);
    drive(32'h0000_0004, 32'h2222_2222, 5'd1, 5'd2, 1'b0);
    drive(32'h0000_0006, 32'h1234_5678, 5'd1, 5'd2, 1'b0);
    mid();
    chk("lit_multi_nobyp", bus1.oRdata1, 32'h1111_1111);
    drive(32'h0000_0010, 32'h0000_0044, 5'd1, 5'd2, 1'b0);
    mid();
    chk("lit_multi_r1", bus0.oRdata1, 32'h1111_1111);
    chk("lit_multi_r2", bus0.oRdata2, 32'h2222_2222);
    chk("lit_multi_err", {31'h0, bus0.oErr}, 32'h1);
    drive(32'h0, 32'h0, 5'd4, 5'd4, 1'b0);
    mid();
    chk("lit_err_sticky", {31'h0, bus1.oErr}, 32'h1);

    // Reset has priority over a write in the same cycle.
    drive(32'h8000_0000, 32'hA5A5_A5A5, 5'd31, 5'd5, 1'b0);
    drive(32'h0000_0020, 32'h0000_0001, 5'd31, 5'd5, 1'b1);
    mid();
    chk("lit_rst_pre", bus0.oRdata1, 32'hA5A5_A5A5);
    chk("lit_rst_nobyp", bus1.oRdata2, 32'h0);
    drive(32'h0, 32'h0, 5'd31, 5'd5, 1'b0);
    mid();
    chk("lit_rst_r31", bus0.oRdata1, 32'h0);
    chk("lit_rst_r5", bus0.oRdata2, 32'h0);
    chk("lit_rst_cnt", {16'h0, bus0.oWrCount}, 32'h0);
    chk("lit_rst_err", {31'h0, bus0.oErr}, 32'h0);

    // Seventeen back-to-back writes wrap the 4-bit counter to 1.
    for (int k = 0; k < 17; k++) drive(32'h0000_0080, 32'(k + 100), 5'd7, 5'd7, 1'b0);
    drive(32'h0, 32'h0, 5'd7, 5'd7, 1'b0);
    mid();
    chk("lit_wrap4", {28'h0, bus1.oWrCount}, 32'h1);
    chk("lit_cnt17", {16'h0, bus0.oWrCount}, 32'd17);
    chk("lit_last_wins", bus0.oRdata2, 32'd116);

    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 50)      v = 32'h1 << $urandom_range(1, 31);
      else if (sel < 62) v = 32'h0;
      else if (sel < 70) v = 32'h1;
      else if (sel < 78) begin
        v = $urandom;
        if ($countones(v) < 2) v = v | (32'h3 << $urandom_range(0, 30));
      end else           v = 32'h1 << $urandom_range(1, 31);
      if ($urandom_range(0, 3) == 0) tb_a2 = tb_a1;
      drive(v, $urandom, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? tb_a1 : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 99) < 3));
    end
    drive(32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
